// File: rtl/calc1_req_driver_if.sv
// Host and calc1-facing signal bundle for calc1_req_driver.
// The master modport is the environment (host plus calc1 port); the slave modport is the driver.
interface calc1_req_driver_if;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_cmd;
    logic [31:0] op_data1;
    logic [31:0] op_data2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_code;
    logic [31:0] rsp_data;
    logic [3:0]  req_cmd_out;
    logic [31:0] req_data_out;
    logic [1:0]  calc_resp;
    logic [31:0] calc_data;
    logic        stray_resp;
    logic [7:0]  ops_done;

    modport master (
        output op_valid, op_cmd, op_data1, op_data2, rsp_ready, calc_resp, calc_data,
        input  op_ready, rsp_valid, rsp_code, rsp_data, req_cmd_out, req_data_out,
               stray_resp, ops_done
    );

    modport slave (
        input  op_valid, op_cmd, op_data1, op_data2, rsp_ready, calc_resp, calc_data,
        output op_ready, rsp_valid, rsp_code, rsp_data, req_cmd_out, req_data_out,
               stray_resp, ops_done
    );
endinterface

// File: rtl/calc1_req_driver.sv
// Queues host operations in a small FIFO and drives them one at a time into a calc1
// request port (command cycle, operand cycle, wait for response), returning one result per op.
module calc1_req_driver #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              c_clk,
    input  logic              reset,
    calc1_req_driver_if.slave bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND1,
        S_SEND2,
        S_WAIT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] data1;
        logic [31:0] data2;
    } entry_t;

    function automatic logic cmd_ok(input logic [3:0] c);
        return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
    endfunction

    // ---------------- command FIFO ----------------
    entry_t             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    entry_t             w_head;
    entry_t             w_new;

    state_t             r_state;

    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.op_valid && !w_full;
    assign w_pop   = (r_state == S_IDLE) && !w_empty;
    assign w_head  = r_mem[r_rd_ptr];
    assign w_new   = '{cmd: bus.op_cmd, data1: bus.op_data1, data2: bus.op_data2};

    // NOTE: FIFO storage is not reset; only the pointers and count define which entries are valid.
    always_ff @(posedge c_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_new;
        end
    end

    // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- request FSM ----------------
    logic [31:0]        r_data2;
    logic [TO_W-1:0]    r_to_cnt;
    logic [3:0]         r_req_cmd;
    logic [31:0]        r_req_data;
    logic               r_rsp_valid;
    logic [1:0]         r_rsp_code;
    logic [31:0]        r_rsp_data;
    logic               r_stray;
    logic [7:0]         r_ops_done;

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_data2     <= '0;
            r_to_cnt    <= '0;
            r_req_cmd   <= '0;
            r_req_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_code  <= '0;
            r_rsp_data  <= '0;
            r_stray     <= 1'b0;
            r_ops_done  <= '0;
        end else begin
            // calc1 only answers while we wait; anything else is logged and dropped
            if ((bus.calc_resp != 2'd0) && (r_state != S_WAIT)) begin
                r_stray <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_data2 <= w_head.data2;
                        if (cmd_ok(w_head.cmd)) begin
                            r_req_cmd  <= w_head.cmd;
                            r_req_data <= w_head.data1;
                            r_state    <= S_SEND1;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_code  <= 2'd2;
                            r_rsp_data  <= '0;
                            r_state     <= S_DONE;
                        end
                    end
                end

                S_SEND1: begin
                    r_req_cmd  <= '0;
                    r_req_data <= r_data2;
                    r_state    <= S_SEND2;
                end

                S_SEND2: begin
                    r_req_data <= '0;
                    r_to_cnt   <= '0;
                    r_state    <= S_WAIT;
                end

                S_WAIT: begin
                    // a response arriving on the last allowed cycle still beats the timeout
                    if (bus.calc_resp != 2'd0) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_code  <= bus.calc_resp;
                        r_rsp_data  <= bus.calc_data;
                        r_state     <= S_DONE;
                    end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_code  <= 2'd3;
                        r_rsp_data  <= '0;
                        r_state     <= S_DONE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end

                S_DONE: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_code  <= '0;
                        r_rsp_data  <= '0;
                        if (r_ops_done != 8'hFF) begin
                            r_ops_done <= r_ops_done + 8'd1;
                        end
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.op_ready     = !w_full;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_code     = r_rsp_code;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.req_cmd_out  = r_req_cmd;
    assign bus.req_data_out = r_req_data;
    assign bus.stray_resp   = r_stray;
    assign bus.ops_done     = r_ops_done;

endmodule
